// File: rtl/model_coefficient_bank_pkg.sv
// rtl/model_coefficient_bank_pkg.sv - shared constants and index helpers for the LPC coefficient bank
package model_coefficient_bank_pkg;

  localparam int          WIDTH   = 32;
  localparam int          ORDER   = 12;
  localparam int          IDX_W   = 4;
  localparam logic [31:0] ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] max_idx);
    return idx <= max_idx;
  endfunction

  // Entry 0 holds a0 = 1.0 and is never a legal write target.
  function automatic logic idx_writable(input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] max_idx);
    return (idx != '0) && (idx <= max_idx);
  endfunction

endpackage

// File: rtl/model_coefficient_bank_coef_bank_ram.sv
// rtl/model_coefficient_bank_coef_bank_ram.sv - one coefficient bank: three registered reads, prioritised writes
module coef_bank_ram
  import model_coefficient_bank_pkg::*;
#(
  parameter int          ORDER = model_coefficient_bank_pkg::ORDER,
  parameter int          WIDTH = model_coefficient_bank_pkg::WIDTH,
  parameter logic [31:0] ONE   = model_coefficient_bank_pkg::ONE
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [IDX_W-1:0] iRdAddr1,
  input  logic [IDX_W-1:0] iRdAddr2,
  input  logic [IDX_W-1:0] iRdAddr3,
  output logic [WIDTH-1:0] oRdData1,
  output logic [WIDTH-1:0] oRdData2,
  output logic [WIDTH-1:0] oRdData3,
  input  logic             iWrEnK,
  input  logic [IDX_W-1:0] iWrAddrK,
  input  logic [WIDTH-1:0] iWrDataK,
  input  logic             iWrEn1,
  input  logic [IDX_W-1:0] iWrAddr1,
  input  logic [WIDTH-1:0] iWrData1,
  input  logic             iWrEn2,
  input  logic [IDX_W-1:0] iWrAddr2,
  input  logic [WIDTH-1:0] iWrData2
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ORDER);

  logic [WIDTH-1:0] mem [0:ORDER];

  // Priority per entry: Km load, then port 1, then port 2. Entry 0 is only set by reset.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      mem[0] <= WIDTH'(ONE);
      for (int i = 1; i <= ORDER; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= ORDER; i++) begin
        if (iWrEnK && (iWrAddrK == IDX_W'(i))) begin
          mem[i] <= iWrDataK;
        end else if (iWrEn1 && (iWrAddr1 == IDX_W'(i))) begin
          mem[i] <= iWrData1;
        end else if (iWrEn2 && (iWrAddr2 == IDX_W'(i))) begin
          mem[i] <= iWrData2;
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oRdData1 <= '0;
      oRdData2 <= '0;
      oRdData3 <= '0;
    end else begin
      oRdData1 <= idx_in_range(iRdAddr1, MAX_IDX) ? mem[iRdAddr1] : '0;
      oRdData2 <= idx_in_range(iRdAddr2, MAX_IDX) ? mem[iRdAddr2] : '0;
      oRdData3 <= idx_in_range(iRdAddr3, MAX_IDX) ? mem[iRdAddr3] : '0;
    end
  end

endmodule

// File: rtl/model_coefficient_bank.sv
// rtl/model_coefficient_bank.sv - double-buffered Levinson-Durbin coefficient store with swap commit
module model_coefficient_bank
  import model_coefficient_bank_pkg::*;
#(
  parameter int          ORDER = model_coefficient_bank_pkg::ORDER,
  parameter int          WIDTH = model_coefficient_bank_pkg::WIDTH,
  parameter logic [31:0] ONE   = model_coefficient_bank_pkg::ONE
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [IDX_W-1:0] iSel1,
  input  logic [IDX_W-1:0] iSel2,
  output logic [WIDTH-1:0] oModel1,
  output logic [WIDTH-1:0] oModel2,
  input  logic             iWrValid,
  input  logic [IDX_W-1:0] iTarget1,
  input  logic [IDX_W-1:0] iTarget2,
  input  logic [WIDTH-1:0] iData1,
  input  logic [WIDTH-1:0] iData2,
  input  logic             iOnlyOne,
  input  logic             iLoadKm,
  input  logic [IDX_W-1:0] iM,
  input  logic [WIDTH-1:0] iKm,
  input  logic             iSwap,
  input  logic [IDX_W-1:0] iRdAddr,
  output logic [WIDTH-1:0] oRdData,
  output logic [IDX_W-1:0] oOrder,
  output logic             oError
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ORDER);

  logic             active_sel;
  logic             rd_sel_q;
  logic             wr1_ok;
  logic             wr2_ok;
  logic             km_ok;
  logic             illegal;
  logic [1:0]       shadow_en;
  logic [WIDTH-1:0] model1   [2];
  logic [WIDTH-1:0] model2   [2];
  logic [WIDTH-1:0] rd_data  [2];

  // Target 0 is dropped without complaint; out-of-range targets and bad Km orders flag an error.
  always_comb begin
    wr1_ok  = iWrValid && idx_writable(iTarget1, MAX_IDX);
    wr2_ok  = iWrValid && !iOnlyOne && idx_writable(iTarget2, MAX_IDX);
    km_ok   = iLoadKm && idx_writable(iM, MAX_IDX);
    illegal = (iWrValid && !idx_in_range(iTarget1, MAX_IDX))
            || (iWrValid && !iOnlyOne && !idx_in_range(iTarget2, MAX_IDX))
            || (iLoadKm && !idx_writable(iM, MAX_IDX));
    shadow_en    = 2'b00;
    shadow_en[0] = active_sel;
    shadow_en[1] = !active_sel;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    coef_bank_ram #(
      .ORDER (ORDER),
      .WIDTH (WIDTH),
      .ONE   (ONE)
    ) u_bank (
      .iClock   (iClock),
      .iReset   (iReset),
      .iRdAddr1 (iSel1),
      .iRdAddr2 (iSel2),
      .iRdAddr3 (iRdAddr),
      .oRdData1 (model1[b]),
      .oRdData2 (model2[b]),
      .oRdData3 (rd_data[b]),
      .iWrEnK   (km_ok && shadow_en[b]),
      .iWrAddrK (iM),
      .iWrDataK (iKm),
      .iWrEn1   (wr1_ok && shadow_en[b]),
      .iWrAddr1 (iTarget1),
      .iWrData1 (iData1),
      .iWrEn2   (wr2_ok && shadow_en[b]),
      .iWrAddr2 (iTarget2),
      .iWrData2 (iData2)
    );
  end

  // rd_sel_q remembers which bank was active when the read was issued, so a read
  // coinciding with a swap still returns the outgoing model.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      active_sel <= 1'b0;
      rd_sel_q   <= 1'b0;
      oOrder     <= '0;
      oError     <= 1'b0;
    end else begin
      rd_sel_q <= active_sel;
      if (iSwap) begin
        active_sel <= !active_sel;
        oOrder     <= iM;
      end
      if (illegal) begin
        oError <= 1'b1;
      end
    end
  end

  always_comb begin
    oModel1 = rd_sel_q ? model1[1]  : model1[0];
    oModel2 = rd_sel_q ? model2[1]  : model2[0];
    oRdData = rd_sel_q ? rd_data[1] : rd_data[0];
  end

endmodule

// File: doc/model_coefficient_bank.md
Name: model_coefficient_bank

Overview:
- Responder for the model-update datapath of the LPC stage: holds the Levinson-Durbin predictor coefficients that the model selector reads (oSel1/oSel2 -> iModel1/iModel2) and writes back (oTarget1/oTarget2, oNewModel1/2, oOnlyOne, oValid).
- Double-buffered. Reads are served from the ACTIVE bank (order m-1 model); writes land in the SHADOW bank (order m model). A swap commits the iteration.
- A third read port exports the committed model to the quantiser/residual stage.

Parameters:
- ORDER, 12, highest predictor order; each bank holds entries 0..ORDER.
- WIDTH, 32, coefficient width (IEEE-754 single).
- ONE, 32'h3F800000, value forced into entry 0 (a0 = 1.0).

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iSel1  in  4  read index A, driven by the selector's oSel1.
- iSel2  in  4  read index B, driven by the selector's oSel2.
- oModel1  out  WIDTH  active[iSel1], registered.
- oModel2  out  WIDTH  active[iSel2], registered.
- iWrValid  in  1  write strobe, from the selector's oValid.
- iTarget1  in  4  write index 1.
- iTarget2  in  4  write index 2.
- iData1  in  WIDTH  data for iTarget1.
- iData2  in  WIDTH  data for iTarget2.
- iOnlyOne  in  1  when high, only iTarget1 is written.
- iLoadKm  in  1  strobe: shadow[iM] <= iKm.
- iM  in  4  current iteration order.
- iKm  in  WIDTH  reflection coefficient k_m.
- iSwap  in  1  commit: shadow becomes active.
- iRdAddr  in  4  export read index.
- oRdData  out  WIDTH  active[iRdAddr], registered.
- oOrder  out  4  order of the active model.
- oError  out  1  sticky illegal-write flag.

Behaviour:
- Reset (synchronous, iReset high at a clock edge):
  - Both banks are zeroed except entry 0, which is set to ONE.
  - Active-bank select = 0; oOrder = 0; oError = 0.
  - oModel1, oModel2 and oRdData = 0.
  - Reset takes priority over every other input, including mid-iteration; shadow contents are discarded.
- Read ports:
  - 1-cycle latency: data for the index presented at edge t is valid after edge t+1.
  - Index > ORDER returns 0.
  - Reads always come from the active bank. A read in the same cycle as iSwap returns old-active data.
- Writes (iWrValid high):
  - shadow[iTarget1] <= iData1.
  - shadow[iTarget2] <= iData2, unless iOnlyOne is high.
  - If iOnlyOne is low and iTarget1 == iTarget2, iData1 wins.
  - Target 0 is ignored silently (a0 is protected).
  - Target > ORDER is ignored and sets oError.
- Km load (iLoadKm high):
  - shadow[iM] <= iKm.
  - If iM is 0 or iM > ORDER, the write is ignored and oError is set.
  - If it coincides with iWrValid to the same index, iKm wins.
- Swap (iSwap high):
  - Active select toggles; oOrder <= iM as sampled that cycle.
  - Writes and Km loads in the same cycle land in the outgoing shadow before the swap, so they are visible as active from edge t+1.
  - The new shadow is not cleared: iteration m rewrites entries 1..m. Entries above m stay at the zeros they held since reset.
- Entry 0 of both banks is never written after reset, so it always reads ONE.
- No internal FSM is needed beyond the active-select flip-flop and the sticky error bit. Sequencing belongs to the controller.
- oError clears only on reset.

Decomposition:
- Shared package holds: WIDTH, ORDER, ONE (FP 1.0) and FP_ZERO.
- One natural sub-module: coef_bank_ram.
  - One bank with ORDER+1 registers, two registered read ports plus one export read port, and two write ports with a write-1-wins priority.
  - Instantiated twice; the top level muxes read and write enables by the active select.

Test Plan:
- Reset, then read sel 0/5/13 -> oModel = 3F800000 / 00000000 / 00000000 one cycle later; oOrder=0; oError=0.
- iM=1, iKm=3F000000, iLoadKm, then iSwap -> oOrder=1; sel1=1 reads 3F000000; export addr 1 matches.
- Iteration m=2: write targets 1/2 with 11111111/22222222 (iOnlyOne=0); reads before swap still return 3F000000 at index 1; after swap, index 1 = 11111111 and index 2 = 22222222.
- iOnlyOne=1 with targets 3/4 -> only entry 3 changes; entry 4 stays at its prior value; target1==target2=5 with iOnlyOne=0 -> iData1 stored.
- Illegal writes: target 0, target 14, iLoadKm with iM=0 -> shadow unchanged, entry 0 still 3F800000, oError=1 and stays 1 until reset.
- Reset asserted mid-iteration (after 3 writes, before swap) -> all entries return to their reset values and oOrder=0; same-cycle write+swap+read: read returns old value, next read returns new.
